// File: rtl/result_seg_display_if.sv
// Display-side signal bundle: the RAM product going in, segment/anode drive and
// the conversion-valid flag coming out.
interface result_seg_display_if;
  logic [7:0] result;
  logic [6:0] seg;
  logic [3:0] an;
  logic       bcd_valid;

  modport master (
    output result,
    input  seg,
    input  an,
    input  bcd_valid
  );

  modport slave (
    input  result,
    output seg,
    output an,
    output bcd_valid
  );
endinterface

// File: rtl/result_seg_display.sv
// Converts the 8-bit product to three BCD digits with a serial double-dabble
// engine and scans them onto a common-anode 7-segment display.
//
// state  | meaning
// S_IDLE | waiting for result to differ from last_val, or a forced conversion
// S_CONV | 8 add-3/shift iterations, then one cycle to hand over to S_LOAD
// S_LOAD | copy bcd into the displayed digit registers, raise bcd_valid
module result_seg_display #(
  parameter int REFRESH_CNT = 100000
) (
  input logic             clk,
  input logic             rst,
  result_seg_display_if.slave bus
);

  localparam int RW = $clog2(REFRESH_CNT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_LOAD = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  shreg, shreg_nx;
  logic [11:0] bcd, bcd_nx;
  logic [11:0] adj;
  logic [3:0]  iter, iter_nx;
  logic [7:0]  last_val, last_nx;
  logic        force_conv, force_nx;
  logic [3:0]  hund, hund_nx;
  logic [3:0]  tens, tens_nx;
  logic [3:0]  ones, ones_nx;
  logic        valid_r, valid_nx;

  logic [RW-1:0] rcnt;
  logic [1:0]    idx;

  logic [3:0]  digit;
  logic        blank;
  logic [6:0]  seg_c;
  logic [3:0]  an_c;

  function automatic logic [11:0] add3(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int i = 0; i < 3; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] c;
    case (d)
      4'd0:    c = 7'b1000000;
      4'd1:    c = 7'b1111001;
      4'd2:    c = 7'b0100100;
      4'd3:    c = 7'b0110000;
      4'd4:    c = 7'b0011001;
      4'd5:    c = 7'b0010010;
      4'd6:    c = 7'b0000010;
      4'd7:    c = 7'b1111000;
      4'd8:    c = 7'b0000000;
      4'd9:    c = 7'b0010000;
      default: c = 7'b1111111;
    endcase
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      shreg      <= '0;
      bcd        <= '0;
      iter       <= '0;
      last_val   <= '0;
      force_conv <= 1'b1;
      hund       <= '0;
      tens       <= '0;
      ones       <= '0;
      valid_r    <= 1'b0;
    end else begin
      state      <= state_nx;
      shreg      <= shreg_nx;
      bcd        <= bcd_nx;
      iter       <= iter_nx;
      last_val   <= last_nx;
      force_conv <= force_nx;
      hund       <= hund_nx;
      tens       <= tens_nx;
      ones       <= ones_nx;
      valid_r    <= valid_nx;
    end
  end

  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    bcd_nx   = bcd;
    iter_nx  = iter;
    last_nx  = last_val;
    force_nx = force_conv;
    hund_nx  = hund;
    tens_nx  = tens;
    ones_nx  = ones;
    valid_nx = valid_r;
    adj      = '0;
    case (state)
      S_IDLE: begin
        if ((bus.result != last_val) || force_conv) begin
          state_nx = S_CONV;
          shreg_nx = bus.result;
          last_nx  = bus.result;
          bcd_nx   = '0;
          force_nx = 1'b0;
          iter_nx  = '0;
        end
      end
      S_CONV: begin
        // result is deliberately not sampled here; IDLE re-checks it afterwards
        if (iter == 4'd8) begin
          state_nx = S_LOAD;
        end else begin
          adj                = add3(bcd);
          {bcd_nx, shreg_nx} = {adj[10:0], shreg, 1'b0};
          iter_nx            = iter + 4'd1;
        end
      end
      S_LOAD: begin
        hund_nx  = bcd[11:8];
        tens_nx  = bcd[7:4];
        ones_nx  = bcd[3:0];
        valid_nx = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Scan is free-running; a LOAD lands on whichever digit is lit
  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt <= '0;
      idx  <= '0;
    end else if (rcnt == RW'(REFRESH_CNT - 1)) begin
      rcnt <= '0;
      idx  <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end else begin
      rcnt <= rcnt + RW'(1);
    end
  end

  always_comb begin
    digit = ones;
    blank = 1'b0;
    case (idx)
      2'd0: begin
        digit = ones;
        blank = 1'b0;
      end
      2'd1: begin
        digit = tens;
        blank = (hund == 4'd0) && (tens == 4'd0);
      end
      2'd2: begin
        digit = hund;
        blank = (hund == 4'd0);
      end
      default: blank = 1'b1;
    endcase
    seg_c = blank ? 7'b1111111 : seg_code(digit);
    an_c  = ~(4'b0001 << idx);
  end

  assign bus.seg       = seg_c;
  assign bus.an        = an_c;
  assign bus.bcd_valid = valid_r;

endmodule

// File: doc/result_seg_display.md
# result_seg_display

Sequential display back-end that consumes the 8-bit product read out of the lab datapath RAM (`result`) and shows it in decimal on a common-anode 4-digit seven-segment display. It converts the product to three BCD digits with an iterative shift-add-3 (double-dabble) engine and time-multiplexes the digits with a refresh counter. It sits directly downstream of the RAM data output in the top level, and its `seg`/`an` outputs go straight to board pins.

## Interface
- `REFRESH_CNT`, default 100000: clock cycles each digit stays lit before the scan advances. Must be ≥ 2. Benches use 4.
- `clk` input 1: system clock, the single clock domain.
- `rst` input 1: reset. Synchronous and active-high.
- `result` input 8: unsigned product from the RAM data output, range 0..255.
- `seg` output 7: segment drive, active-low. Bit order is `{g,f,e,d,c,b,a}`.
- `an` output 4: digit enables, active-low. `an[0]` is the ones digit; `an[3]` is unused and held at 1.
- `bcd_valid` output 1: level signal. High once the first conversion after reset has completed.

## Operation
- Converter FSM states:
  - IDLE:
    - Go to CONV when `result != last_val` or `force` is set.
    - On the transition: latch `result` into `shreg[7:0]` and `last_val`, clear `bcd[11:0]`, clear `force`, set `iter = 0`.
  - CONV: runs 8 iterations, one per clock.
    - Each iteration: for every nibble of `bcd` that is ≥ 5, add 3.
    - Then shift `{bcd,shreg}` left by 1.
    - Increment `iter`. After the 8th iteration go to LOAD.
  - LOAD:
    - Copy `bcd` into `hund`, `tens`, `ones` (4 bits each).
    - Set `bcd_valid = 1` and return to IDLE.
- A change on `result` during CONV or LOAD is not sampled. After returning to IDLE the FSM compares `result` against `last_val` again and re-converts if they differ, so the final display always matches the last stable `result`.
- Digit blanking:
  - `hund` is blank when it is 0.
  - `tens` is blank when `hund` and `tens` are both 0.
  - `ones` is never blank.
- Scan logic:
  - `rcnt` counts `0..REFRESH_CNT-1` and wraps.
  - On each wrap, `idx` advances 0→1→2→0. Only 3 digits are scanned.
  - `an = ~(4'b0001 << idx)`, so `an[3]` is always 1.
  - `seg` shows the decoded digit selected by `idx`.
- Segment codes (gfedcba):

  | Digit | Code | Digit | Code |
  |---|---|---|---|
  | 0 | 1000000 | 5 | 0010010 |
  | 1 | 1111001 | 6 | 0000010 |
  | 2 | 0100100 | 7 | 1111000 |
  | 3 | 0110000 | 8 | 0000000 |
  | 4 | 0011001 | 9 | 0010000 |
  | blank | 1111111 | | |

- BCD values 10..15 cannot occur. The decoder must drive blank for them.

## Timing
- Reset, synchronous, all registers:
  - FSM = IDLE, `force = 1`, `last_val = 0`.
  - `hund`, `tens`, `ones` = 0; `bcd_valid = 0`.
  - `rcnt = 0`, `idx = 0`.
- Outputs one cycle after the reset edge: `an = 4'b1110`, `seg = 1000000` (shows "0"), `bcd_valid = 0`.
- Asserting `rst` mid-conversion aborts the conversion. Partial BCD is never loaded.
- Latency:
  - Cycle N: `result` changes (or `force` is set) while in IDLE.
  - Edge N+1: latch, enter CONV.
  - Edges N+2..N+9: 8 iterations.
  - Edge N+10: LOAD.
  - New digits and `bcd_valid` are visible after edge N+11, i.e. 11 cycles from input change to display update.
- Minimum spacing between conversions is 11 cycles. At most one conversion is in flight.
- `seg` and `an` are decoded from registers only (`idx`, digit registers). There is no combinational path from `result`.
- `idx` changes on the edge where `rcnt` wraps from `REFRESH_CNT-1` to 0. `an` and `seg` change together on that edge.
- The scan runs independently of the converter. A LOAD takes effect on whichever digit is currently lit, with no scan restart.

## Test plan
- Reset then idle with `result = 0`:
  - `an = 1110`, `seg = 1000000`.
  - `bcd_valid` rises 11 cycles after reset release (forced conversion).
  - Digits 1 and 2 show blank (`seg = 1111111`) when scanned.
- `result = 8'd255`:
  - After 11 cycles, `hund/tens/ones = 2/5/5`.
  - Scan with `REFRESH_CNT = 4` shows `an = 1110` with `seg = 0010010`, then `an = 1101` with `seg = 0010010`, then `an = 1011` with `seg = 0100100`.
  - Each digit is held for 4 cycles.
- `result = 8'd7`: ones = `1111000`; tens and hundreds blank. Then `result = 8'd40`: ones = `1000000`, tens = `0011001`, hundreds blank.
- `result` changes from 12 to 99 at cycle 3 of CONV:
  - First the display shows 12.
  - Then a second conversion starts automatically; 99 is displayed 11 cycles after the first LOAD.
- Assert `rst` for 1 cycle in mid-CONV while converting 200:
  - Digits return to 0 and `bcd_valid = 0`.
  - The forced reconversion of the still-present 200 completes 11 cycles after reset release.
- Sweep `result` 0..255, waiting 12 cycles each: `{hund,tens,ones}` equals the decimal value every time, `an[3]` stays 1 throughout, and codes 10..15 never appear.
